// File: rtl/tone_square_gen_if.sv
// Tone generator control/output bundle: en/div in, square wave and status out.
// The sample signal exists only when TONE_SAMPLE_EN is defined.
interface tone_square_gen_if #(
  parameter int unsigned DIV_W = 32
`ifdef TONE_SAMPLE_EN
  ,
  parameter int unsigned SAMPLE_W = 24
`endif
);
  logic             en;
  logic [DIV_W-1:0] div;
  logic             audio_out;
  logic             toggle;
  logic             active;
`ifdef TONE_SAMPLE_EN
  logic [SAMPLE_W-1:0] sample;
`endif

  modport master (
    output en,
    output div,
`ifdef TONE_SAMPLE_EN
    input  sample,
`endif
    input  audio_out,
    input  toggle,
    input  active
  );

  modport slave (
    input  en,
    input  div,
`ifdef TONE_SAMPLE_EN
    output sample,
`endif
    output audio_out,
    output toggle,
    output active
  );
endinterface

// File: rtl/tone_square_gen.sv
// Square-wave tone generator: audio_out holds each level for div clocks, div == 0 is silence.
// Optional signed sample output enabled by the TONE_SAMPLE_EN macro.
module tone_square_gen #(
  parameter int unsigned DIV_W = 32
`ifdef TONE_SAMPLE_EN
  ,
  parameter int unsigned SAMPLE_W  = 24,
  parameter int unsigned AMPLITUDE = 4194303
`endif
) (
  input logic               clk,
  input logic               reset,
  tone_square_gen_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic             audio_q, audio_d;
  logic             toggle_q, toggle_d;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    cur_div_d = cur_div_q;
    audio_d   = audio_q;
    toggle_d  = 1'b0;

    // Mute overrides everything, including a coincident half-period boundary.
    if (!bus.en) begin
      state_d   = StIdle;
      count_d   = '0;
      cur_div_d = '0;
      audio_d   = 1'b0;
      toggle_d  = audio_q;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.div != '0) begin
            state_d   = StRun;
            cur_div_d = bus.div;
            count_d   = '0;
            audio_d   = 1'b1;
            toggle_d  = 1'b1;
          end
        end
        StRun: begin
          if (count_q != cur_div_q - DIV_W'(1)) begin
            count_d = count_q + DIV_W'(1);
          end else begin
            count_d = '0;
            if (bus.div != '0) begin
              cur_div_d = bus.div;
              audio_d   = ~audio_q;
              toggle_d  = 1'b1;
            end else begin
              state_d  = StIdle;
              audio_d  = 1'b0;
              toggle_d = audio_q;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      cur_div_q <= '0;
      audio_q   <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      cur_div_q <= cur_div_d;
      audio_q   <= audio_d;
      toggle_q  <= toggle_d;
    end
  end

  assign bus.audio_out = audio_q;
  assign bus.toggle    = toggle_q;
  assign bus.active    = (state_q == StRun);

`ifdef TONE_SAMPLE_EN
  localparam logic [SAMPLE_W-1:0] SampPos = SAMPLE_W'(AMPLITUDE);
  localparam logic [SAMPLE_W-1:0] SampNeg = SAMPLE_W'(0) - SampPos;

  logic [SAMPLE_W-1:0] sample_q, sample_d;

  always_comb begin
    sample_d = '0;
    if (state_d == StRun) begin
      sample_d = audio_d ? SampPos : SampNeg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q <= '0;
    end else begin
      sample_q <= sample_d;
    end
  end

  assign bus.sample = sample_q;
`endif

endmodule

// File: tb/tb_tone_square_gen.sv
// Scoreboard bench for tone_square_gen: driver queues hand-derived per-edge expectations,
// a monitor pops and checks them each cycle. Sample checks apply when TONE_SAMPLE_EN is set.
module tb_tone_square_gen;

  localparam int unsigned DIV_W = 32;
  localparam logic [23:0] SampPos = 24'd100;
  localparam logic [23:0] SampNeg = 24'hFFFF9C;

  typedef struct {
    string       name;
    logic [2:0]  exp;   // {audio_out, toggle, active}
    logic [23:0] smp;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

`ifdef TONE_SAMPLE_EN
  tone_square_gen_if #(.DIV_W(DIV_W), .SAMPLE_W(24)) bus ();
  tone_square_gen #(.DIV_W(DIV_W), .SAMPLE_W(24), .AMPLITUDE(100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );
`else
  tone_square_gen_if #(.DIV_W(DIV_W)) bus ();
  tone_square_gen #(.DIV_W(DIV_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );
`endif

  // Drive one edge's inputs and queue the outputs expected after that edge.
  task automatic step(input string name, input logic rst, input logic en, input logic [31:0] div,
                      input logic ea, input logic et, input logic eact);
    exp_t e;
    @(negedge clk);
    #1;
    reset  = rst;
    bus.en = en;
    bus.div = div;
    e.name = name;
    e.exp  = {ea, et, eact};
    e.smp  = eact ? (ea ? SampPos : SampNeg) : 24'd0;
    sb_q.push_back(e);
  endtask

  // One full level of n edges while running; the first edge carries the toggle.
  task automatic level(input string name, input logic [31:0] div, input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      step(name, 1'b0, 1'b1, div, lvl, (i == 0), 1'b1);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if ({bus.audio_out, bus.toggle, bus.active} !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got {audio,toggle,active}=%b expected %b at %0t",
                   e.name, {bus.audio_out, bus.toggle, bus.active}, e.exp, $time);
        end
`ifdef TONE_SAMPLE_EN
        n_cmp++;
        if (bus.sample !== e.smp) begin
          n_bad++;
          $display("FAIL %s sample: got %h expected %h at %0t", e.name, bus.sample, e.smp, $time);
        end
`endif
      end
    end
  end

  initial begin : driver
    reset  = 1'b1;
    bus.en = 1'b1;
    bus.div = 32'd3;

    // Reset held two clocks, then div=3 run
    step("rst", 1'b1, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
    step("rst", 1'b1, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
    level("d3_hi", 32'd3, 1'b1, 3);
    level("d3_lo", 32'd3, 1'b0, 3);
    level("d3_hi2", 32'd3, 1'b1, 3);
    level("d3_lo2", 32'd3, 1'b0, 3);

    // div 3 -> 5 one clock after a rising toggle: current high still 3 long
    step("chg_rise", 1'b0, 1'b1, 32'd3, 1'b1, 1'b1, 1'b1);
    step("chg_hold", 1'b0, 1'b1, 32'd5, 1'b1, 1'b0, 1'b1);
    step("chg_hold", 1'b0, 1'b1, 32'd5, 1'b1, 1'b0, 1'b1);
    level("d5_lo", 32'd5, 1'b0, 5);
    level("d5_hi", 32'd5, 1'b1, 5);

    // div 4, then div=0 mid high level: silence only at the boundary
    level("d4_lo", 32'd4, 1'b0, 4);
    step("d4_hi", 1'b0, 1'b1, 32'd4, 1'b1, 1'b1, 1'b1);
    step("d4_hi", 1'b0, 1'b1, 32'd4, 1'b1, 1'b0, 1'b1);
    step("d0_wait", 1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
    step("d0_wait", 1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
    step("d0_fall", 1'b0, 1'b1, 32'd0, 1'b0, 1'b1, 1'b0);
    step("d0_idle", 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    step("d0_idle", 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);

    // div=1 toggles every clock
    for (int i = 0; i < 6; i++) begin
      step("d1", 1'b0, 1'b1, 32'd1, (i % 2 == 0), 1'b1, 1'b1);
    end
    // Large divider: one full high level of 47774 clocks, then the fall
    level("dBA9E_hi", 32'h0000BA9E, 1'b1, 47774);
    step("dBA9E_fall", 1'b0, 1'b1, 32'h0000BA9E, 1'b0, 1'b1, 1'b1);
    step("mute_lo", 1'b0, 1'b0, 32'h0000BA9E, 1'b0, 1'b0, 1'b0);

    // div=6, mute mid-level, restart gives a fresh full level
    step("d6_hi", 1'b0, 1'b1, 32'd6, 1'b1, 1'b1, 1'b1);
    step("d6_hi", 1'b0, 1'b1, 32'd6, 1'b1, 1'b0, 1'b1);
    step("d6_hi", 1'b0, 1'b1, 32'd6, 1'b1, 1'b0, 1'b1);
    step("mute_hi", 1'b0, 1'b0, 32'd6, 1'b0, 1'b1, 1'b0);
    level("d6_restart", 32'd6, 1'b1, 6);
    step("d6_fall", 1'b0, 1'b1, 32'd6, 1'b0, 1'b1, 1'b1);
    step("d6_lo", 1'b0, 1'b1, 32'd6, 1'b0, 1'b0, 1'b1);
    // Reset mid-level beats en and the running count
    step("rst_mid", 1'b1, 1'b1, 32'd6, 1'b0, 1'b0, 1'b0);
    level("d6_after_rst", 32'd6, 1'b1, 6);
    step("d6_fall2", 1'b0, 1'b1, 32'd6, 1'b0, 1'b1, 1'b1);
    step("mute_lo2", 1'b0, 1'b0, 32'd6, 1'b0, 1'b0, 1'b0);

    // div=2 run for the sample sequence, ended by div=0 while high
    level("d2_hi", 32'd2, 1'b1, 2);
    level("d2_lo", 32'd2, 1'b0, 2);
    step("d2_hi2", 1'b0, 1'b1, 32'd2, 1'b1, 1'b1, 1'b1);
    step("d2_hi2", 1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
    step("d2_stop", 1'b0, 1'b1, 32'd0, 1'b0, 1'b1, 1'b0);
    step("d2_idle", 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);

    // Let the monitor drain; leftover entries mean lost checks
    repeat (4) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
